// File: rtl/mac_loop_ctrl.sv
// mac_loop_ctrl: nested-loop address generator that sequences one MAC engine job.
// Build option MAC_LOOP_CTRL_PERF_EN adds an address-stall counter at register 15.
module mac_loop_ctrl #(
  parameter int N_CORES  = 2,
  parameter int NB_LOOPS = 2,
  parameter int CNT_W    = 12
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               cfg_we_i,
  input  logic [3:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic [31:0]        addr_o,
  output logic               addr_valid_o,
  input  logic               addr_ready_i,
  output logic               eng_start_o,
  output logic [CNT_W-1:0]   eng_len_o,
  input  logic               eng_done_i,
  output logic               busy_o,
  output logic [N_CORES-1:0] evt_o,
  output logic [2:0]         dbg_state_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ISSUE, S_WAIT_ENG, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  range_q [NB_LOOPS];
  logic [31:0]       stride_q [NB_LOOPS];
  logic [CNT_W-1:0]  idx_q [NB_LOOPS];
  logic [CNT_W-1:0]  idx_nx [NB_LOOPS];
  logic [31:0]       off_q [NB_LOOPS];
  logic [31:0]       off_nx [NB_LOOPS];
  logic [31:0]       addr_q, addr_nx, rdata_q, rdata_d;
  logic              done_q, trig, hs, last_tuple;

  // Address handshake: addr_o/addr_valid_o hold steady until a cycle with
  // addr_valid_o & addr_ready_i; that cycle transfers exactly one address.
  assign trig = cfg_we_i && (cfg_addr_i == 4'd0);
  assign hs   = (state_q == S_ISSUE) && addr_ready_i;

  assign busy_o       = (state_q != S_IDLE);
  assign addr_valid_o = (state_q == S_ISSUE);
  assign eng_start_o  = (state_q == S_START);
  assign evt_o        = (state_q == S_DONE) ? '1 : '0;
  assign eng_len_o    = busy_o ? len_q + CNT_W'(1) : '0;
  assign addr_o       = addr_q;
  assign cfg_rdata_o  = rdata_q;
  assign dbg_state_o  = state_q;

  // Odometer step: a loop advances only when every inner loop wraps.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    addr_nx = base_q;
    for (int k = 0; k < NB_LOOPS; k++) begin
      idx_nx[k] = idx_q[k];
      off_nx[k] = off_q[k];
      if (carry) begin
        if (idx_q[k] == range_q[k]) begin
          idx_nx[k] = '0;
          off_nx[k] = '0;
        end else begin
          idx_nx[k] = idx_q[k] + CNT_W'(1);
          off_nx[k] = off_q[k] + stride_q[k];
        end
      end
      carry   = carry && (idx_q[k] == range_q[k]);
      addr_nx = addr_nx + off_nx[k];
    end
    last_tuple = carry;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (trig) state_d = S_START;
      S_START:    state_d = S_ISSUE;
      S_ISSUE:    if (hs && last_tuple) state_d = S_WAIT_ENG;
      S_WAIT_ENG: if (done_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

`ifdef MAC_LOOP_CTRL_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  stall_q <= '0;
    else if (clear_i || state_q == S_START)       stall_q <= '0;
    else if (addr_valid_o && !addr_ready_i && stall_q != '1)
                                                  stall_q <= stall_q + 32'd1;
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (cfg_addr_i)
      4'd1:    rdata_d = {31'd0, busy_o};
      4'd2:    rdata_d = base_q;
      4'd3:    rdata_d = 32'(len_q);
`ifdef MAC_LOOP_CTRL_PERF_EN
      4'd15:   rdata_d = stall_q;
`endif
      default: rdata_d = '0;
    endcase
    for (int k = 0; k < NB_LOOPS; k++) begin
      if (cfg_addr_i == 4'(4 + 2 * k)) rdata_d = 32'(range_q[k]);
      if (cfg_addr_i == 4'(5 + 2 * k)) rdata_d = stride_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      base_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      for (int k = 0; k < NB_LOOPS; k++) begin
        range_q[k]  <= '0;
        stride_q[k] <= '0;
        idx_q[k]    <= '0;
        off_q[k]    <= '0;
      end
    end else begin
      rdata_q <= rdata_d;
      if (cfg_we_i && !busy_o) begin
        if (cfg_addr_i == 4'd2) base_q <= cfg_wdata_i;
        if (cfg_addr_i == 4'd3) len_q  <= cfg_wdata_i[CNT_W-1:0];
        for (int k = 0; k < NB_LOOPS; k++) begin
          if (cfg_addr_i == 4'(4 + 2 * k)) range_q[k]  <= cfg_wdata_i[CNT_W-1:0];
          if (cfg_addr_i == 4'(5 + 2 * k)) stride_q[k] <= cfg_wdata_i;
        end
      end
      if (state_q == S_IDLE && trig) begin
        addr_q <= base_q;
        for (int k = 0; k < NB_LOOPS; k++) begin
          idx_q[k] <= '0;
          off_q[k] <= '0;
        end
      end else if (hs) begin
        addr_q <= addr_nx;
        for (int k = 0; k < NB_LOOPS; k++) begin
          idx_q[k] <= idx_nx[k];
          off_q[k] <= off_nx[k];
        end
      end
      // Engine completion may arrive before the last address is issued.
      if (state_q == S_DONE) done_q <= 1'b0;
      else if (eng_done_i && (state_q == S_START || state_q == S_ISSUE ||
                              state_q == S_WAIT_ENG)) done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_loop_ctrl.sv
// Directed bench for mac_loop_ctrl: address list model, register and control checks.
module tb_mac_loop_ctrl;
  localparam int N_CORES  = 2;
  localparam int NB_LOOPS = 2;
  localparam int CNT_W    = 12;

  logic               clk_i, rst_ni, clear_i, cfg_we_i;
  logic [3:0]         cfg_addr_i;
  logic [31:0]        cfg_wdata_i, cfg_rdata_o, addr_o;
  logic               addr_valid_o, addr_ready_i, eng_start_o, eng_done_i, busy_o;
  logic [CNT_W-1:0]   eng_len_o;
  logic [N_CORES-1:0] evt_o;
  logic [2:0]         dbg_state_o;

  mac_loop_ctrl #(.N_CORES(N_CORES), .NB_LOOPS(NB_LOOPS), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .eng_start_o(eng_start_o), .eng_len_o(eng_len_o), .eng_done_i(eng_done_i),
    .busy_o(busy_o), .evt_o(evt_o), .dbg_state_o(dbg_state_o)
  );

  int cmp_cnt = 0, fail_cnt = 0, cyc = 0;
  int evt_cnt = 0, start_cnt = 0, hs_cnt = 0, evt_cyc = 0, last_hs_cyc = 0;
  logic [31:0]        exp_q[$];
  logic [31:0]        acc_q[$];
  logic [CNT_W-1:0]   exp_len;
  logic [N_CORES-1:0] all_ones = '1;
  logic               prev_stall = 1'b0;
  logic [31:0]        prev_addr = '0;
  logic [31:0]        rd;

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_addr_i = a;
    @(posedge clk_i); #1;
    d = cfg_rdata_o;
  endtask

  task automatic set_job(input logic [31:0] base, input logic [31:0] len_f,
                         input logic [31:0] r0f, input logic [31:0] s0,
                         input logic [31:0] r1f, input logic [31:0] s1);
    cfg_write(4'd2, base);
    cfg_write(4'd3, len_f);
    cfg_write(4'd4, r0f);
    cfg_write(4'd5, s0);
    cfg_write(4'd6, r1f);
    cfg_write(4'd7, s1);
    exp_len = CNT_W'(len_f + 1);
    // model: every index tuple in odometer order, address by direct arithmetic
    exp_q.delete();
    for (int i1 = 0; i1 <= int'(r1f); i1++)
      for (int i0 = 0; i0 <= int'(r0f); i0++)
        exp_q.push_back(base + 32'(i0) * s0 + 32'(i1) * s1);
  endtask

  task automatic run_job(input bit toggle, input bit early, input int hold,
                         input bit busy_wr, input logic [31:0] base);
    int s0, e0, h0, total;
    bit done_sent, fin;
    s0 = start_cnt; e0 = evt_cnt; h0 = hs_cnt; total = exp_q.size();
    done_sent = 1'b0; fin = 1'b0;
    acc_q.delete();
    cfg_write(4'd0, 32'd1);
    for (int j = 1; j <= 400 && !fin; j++) begin
      @(posedge clk_i); #1;
      addr_ready_i = toggle ? (j % 2 == 0) : 1'b1;
      if (j <= hold) addr_ready_i = 1'b0;
      if (busy_wr) begin
        if (j == 5) check("status_busy", cfg_rdata_o, 32'd1);
        if (j == 6) check("base_locked", cfg_rdata_o, base);
        case (j)
          2: begin cfg_we_i = 1'b1; cfg_addr_i = 4'd2; cfg_wdata_i = 32'hDEAD0000; end
          3: begin cfg_we_i = 1'b1; cfg_addr_i = 4'd0; cfg_wdata_i = 32'd1; end
          4: begin cfg_we_i = 1'b0; cfg_addr_i = 4'd1; end
          5: cfg_addr_i = 4'd2;
          default: cfg_we_i = 1'b0;
        endcase
      end
      eng_done_i = 1'b0;
      if (early) eng_done_i = (j == 3);
      else if (!done_sent && exp_q.size() == 0) begin
        eng_done_i = 1'b1;
        done_sent  = 1'b1;
      end
      if (evt_cnt > e0 && !busy_o) fin = 1'b1;
    end
    eng_done_i = 1'b0; addr_ready_i = 1'b1; cfg_we_i = 1'b0;
    if (!fin) begin
      cmp_cnt++; fail_cnt++;
      $display("FAIL job_timeout: evt_o/busy_o did not complete within 400 cycles");
    end
    check("handshakes", hs_cnt - h0, total);
    check("start_pulses", start_cnt - s0, 1);
    check("evt_pulses", evt_cnt - e0, 1);
    check("exp_drained", exp_q.size(), 0);
    if (early) check("done_latency", evt_cyc - last_hs_cyc, 2);
  endtask

  // scoreboard / compare process
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (addr_valid_o && prev_stall) check("addr_hold", addr_o, prev_addr);
      if (addr_valid_o && addr_ready_i) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        acc_q.push_back(addr_o);
        if (exp_q.size() == 0) begin
          cmp_cnt++; fail_cnt++;
          $display("FAIL extra_hs: addr 0x%08h accepted with none expected", addr_o);
        end else begin
          check("addr", addr_o, exp_q.pop_front());
        end
      end
      prev_stall = addr_valid_o && !addr_ready_i;
      prev_addr  = addr_o;
      if (evt_o != '0) begin
        evt_cnt++;
        evt_cyc = cyc;
        check("evt_val", 32'(evt_o), 32'(all_ones));
      end
      if (eng_start_o) start_cnt++;
      if (busy_o) check("eng_len", 32'(eng_len_o), 32'(exp_len));
      else check("idle_outputs", {addr_valid_o, eng_start_o, evt_o, eng_len_o}, 32'd0);
    end
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0;
    cfg_wdata_i = '0; addr_ready_i = 1'b1; eng_done_i = 1'b0; exp_len = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_addr", addr_o, 32'd0);
    check("rst_ctrl", {addr_valid_o, eng_start_o, busy_o, evt_o}, 32'd0);
    check("rst_len_rdata", {cfg_rdata_o[19:0], eng_len_o}, 32'd0);
    rst_ni = 1'b1;
    cfg_read(4'd1, rd); check("status_idle", rd, 32'd0);
    cfg_read(4'd2, rd); check("base_reset", rd, 32'd0);

    // basic 3x2 job, ready tied high
    set_job(32'h1000, 32'd7, 32'd2, 32'd4, 32'd1, 32'h100);
    cfg_read(4'd4, rd);  check("range0_rd", rd, 32'd2);
    cfg_read(4'd7, rd);  check("stride1_rd", rd, 32'h100);
    cfg_write(4'd12, 32'hFFFF_FFFF);
    cfg_read(4'd12, rd); check("unmapped_rd", rd, 32'd0);
    run_job(1'b0, 1'b0, 0, 1'b0, 32'h1000);
    check("lit_a0", acc_q[0], 32'h1000);
    check("lit_a2", acc_q[2], 32'h1008);
    check("lit_a3", acc_q[3], 32'h1100);
    check("lit_a5", acc_q[5], 32'h1108);

    // same job, ready toggling
    set_job(32'h1000, 32'd7, 32'd2, 32'd4, 32'd1, 32'h100);
    run_job(1'b1, 1'b0, 0, 1'b0, 32'h1000);
    check("toggle_a4", acc_q[4], 32'h1104);
    cfg_read(4'd15, rd);
`ifdef MAC_LOOP_CTRL_PERF_EN
    check("perf_stalls", rd, 32'd6);
`else
    check("perf_absent", rd, 32'd0);
`endif

    // engine done during ISSUE
    set_job(32'h1000, 32'd7, 32'd2, 32'd4, 32'd1, 32'h100);
    run_job(1'b0, 1'b1, 0, 1'b0, 32'h1000);

    // trigger and BASE written while busy
    set_job(32'h1000, 32'd3, 32'd2, 32'd4, 32'd1, 32'h100);
    run_job(1'b0, 1'b0, 8, 1'b1, 32'h1000);
    cfg_read(4'd2, rd); check("base_after_busy", rd, 32'h1000);

    // negative stride, single outer iteration
    set_job(32'h10, 32'd0, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'h100);
    run_job(1'b0, 1'b0, 0, 1'b0, 32'h10);
    check("neg_a0", acc_q[0], 32'h10);
    check("neg_a1", acc_q[1], 32'h0C);
    check("neg_a3", acc_q[3], 32'h04);

    // reset in the middle of ISSUE
    begin
      int e0;
      set_job(32'h2000, 32'd4, 32'd3, 32'd4, 32'd1, 32'h40);
      cfg_write(4'd0, 32'd1);
      addr_ready_i = 1'b0;
      repeat (3) begin @(posedge clk_i); #1; end
      e0 = evt_cnt;
      rst_ni = 1'b0;
      #1;
      check("midrst_addr", addr_o, 32'd0);
      check("midrst_ctrl", {addr_valid_o, eng_start_o, busy_o, evt_o}, 32'd0);
      check("midrst_len", 32'(eng_len_o), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1; addr_ready_i = 1'b1;
      exp_q.delete();
      repeat (5) begin @(posedge clk_i); #1; end
      check("midrst_no_evt", evt_cnt - e0, 0);
      cfg_read(4'd2, rd); check("midrst_base", rd, 32'd0);
      cfg_read(4'd4, rd); check("midrst_range0", rd, 32'd0);
    end

    // soft clear mid-job, then clear together with trigger
    begin
      int s0;
      set_job(32'h3000, 32'd5, 32'd1, 32'd8, 32'd0, 32'd0);
      cfg_write(4'd0, 32'd1);
      addr_ready_i = 1'b0;
      repeat (2) begin @(posedge clk_i); #1; end
      clear_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0; addr_ready_i = 1'b1;
      exp_q.delete();
      check("clr_ctrl", {addr_valid_o, eng_start_o, busy_o, evt_o}, 32'd0);
      check("clr_addr", addr_o, 32'd0);
      check("clr_rdata", cfg_rdata_o, 32'd0);
      cfg_read(4'd2, rd); check("clr_base", rd, 32'd0);
      cfg_read(4'd3, rd); check("clr_len", rd, 32'd0);
      s0 = start_cnt;
      cfg_we_i = 1'b1; cfg_addr_i = 4'd0; cfg_wdata_i = 32'd1; clear_i = 1'b1;
      @(posedge clk_i); #1;
      cfg_we_i = 1'b0; clear_i = 1'b0;
      repeat (3) begin @(posedge clk_i); #1; end
      check("clr_wins_busy", {31'd0, busy_o}, 32'd0);
      check("clr_wins_start", start_cnt - s0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mac_loop_ctrl.md
MAC_LOOP_CTRL -- requirements
Module: mac_loop_ctrl

Interface
REQ-001 SHALL have parameter N_CORES, default 2: width of event vector, one bit per core.
REQ-002 SHALL have parameter NB_LOOPS, default 2, legal 1..4: number of nested address loops.
REQ-003 SHALL have parameter CNT_W, default 12: width of per-loop index counters and LEN field.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ports clk_i and rst_ni.
REQ-005 SHALL have port clk_i, input, 1: clock.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-008 SHALL have port cfg_we_i, input, 1: register write strobe.
REQ-009 SHALL have port cfg_addr_i, input, 4: register word index.
REQ-010 SHALL have port cfg_wdata_i, input, 32: write data.
REQ-011 SHALL have port cfg_rdata_o, output, 32: read data.
REQ-012 SHALL have port addr_o, output, 32: generated stream address.
REQ-013 SHALL have port addr_valid_o, output, 1: address valid.
REQ-014 SHALL have port addr_ready_i, input, 1: streamer accepts address.
REQ-015 SHALL have port eng_start_o, output, 1: engine start pulse.
REQ-016 SHALL have port eng_len_o, output, CNT_W: engine accumulation length.
REQ-017 SHALL have port eng_done_i, input, 1: engine completion pulse.
REQ-018 SHALL have port busy_o, output, 1: job in progress.
REQ-019 SHALL have port evt_o, output, N_CORES: end-of-job event.

Function
REQ-020 SHALL decode registers: 0 TRIGGER (write only), 1 STATUS (bit0 = busy), 2 BASE, 3 LEN, 4+2k RANGE_k, 5+2k STRIDE_k for k < NB_LOOPS; all other addresses read 0 and ignore writes.
REQ-021 SHALL store LEN and RANGE_k as value-minus-1 (CNT_W LSBs); effective value = field + 1, so 1..2^CNT_W.
REQ-022 SHALL drive cfg_rdata_o registered: the value of the register at cfg_addr_i in the previous cycle.
REQ-023 SHALL drop writes to BASE/LEN/RANGE/STRIDE while busy_o = 1.
REQ-024 SHALL implement FSM IDLE -> START -> ISSUE -> WAIT_ENG -> DONE -> IDLE.
REQ-025 IDLE: write to TRIGGER -> START on the next edge; TRIGGER writes in any other state are ignored.
REQ-026 START: eng_start_o = 1 for exactly one cycle; eng_len_o = LEN+1, held constant through DONE; idx_k = 0; addr = BASE; next state ISSUE.
REQ-027 ISSUE: addr_valid_o = 1; addr_o stable until handshake (addr_valid_o & addr_ready_i).
REQ-028 On handshake: idx_0 increments; on idx_k = RANGE_k it wraps to 0 and carries into idx_k+1 (odometer, loop 0 innermost).
REQ-029 SHALL keep addr_o = BASE + sum(idx_k * STRIDE_k) modulo 2^32, updated by incremental offset accumulators (no multipliers); STRIDE is two's-complement signed.
REQ-030 Handshake on the last tuple (all idx_k at their maxima) -> WAIT_ENG; addr_valid_o deasserts the following cycle; total handshakes = product of ranges.
REQ-031 SHALL latch eng_done_i arriving in START, ISSUE or WAIT_ENG (sticky); WAIT_ENG with latch set -> DONE.
REQ-032 DONE: evt_o = all ones for exactly one cycle; latch cleared; next state IDLE.
REQ-033 busy_o = 1 in every state except IDLE.
REQ-034 clear_i: next cycle state IDLE, counters, latch and all registers zero, outputs at reset values; clear_i wins over simultaneous trigger.

Reset
REQ-035 On rst_ni low: state IDLE; all registers, counters and cfg_rdata_o zero; addr_valid_o, eng_start_o, busy_o, evt_o = 0; addr_o = 0; eng_len_o = 0.
REQ-036 Reset mid-job SHALL abort immediately with no evt_o pulse.

Configuration
REQ-037 Macro MAC_LOOP_CTRL_PERF_EN defined: register 15 reads a 32-bit saturating counter of cycles with addr_valid_o & !addr_ready_i, zeroed at START, reset and clear_i.
REQ-038 Macro not defined: no counter logic; register 15 reads 0.

Verification
REQ-039 NB_LOOPS=2, BASE=0x1000, RANGE_0=3 (field 2), STRIDE_0=4, RANGE_1=2 (field 1), STRIDE_1=0x100, ready tied 1 -> addresses 0x1000,1004,1008,1100,1104,1108, then WAIT_ENG.
REQ-040 Same job, addr_ready_i toggling every other cycle -> same 6 addresses, each held until accepted; with PERF_EN register 15 reads 6.
REQ-041 eng_done_i pulsed during ISSUE -> after last handshake one WAIT_ENG cycle then one-cycle evt_o = 2'b11, busy_o falls.
REQ-042 TRIGGER and BASE written while busy -> no second job, BASE readback unchanged.
REQ-043 STRIDE_0 = 0xFFFFFFFC, BASE=0x10, RANGE_0=4 -> 0x10,0x0C,0x08,0x04.
REQ-044 rst_ni asserted in ISSUE -> all outputs 0 next cycle, no evt_o; clear_i likewise returns IDLE with registers zero.
